// File: rtl/sass_pkg.sv
// Shared widths, per-voice configuration record and scheduler state type
// for the time-multiplexed voice scheduler.
package sass_pkg;

  localparam int unsigned CNT_W    = 19;
  localparam int unsigned MODE_W   = 3;
  localparam int unsigned SAMPLE_W = 8;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'd128;

  typedef struct packed {
    logic [CNT_W-1:0]    divisor;
    logic [MODE_W-1:0]   mode;
    logic [SAMPLE_W-1:0] level;
  } voice_cfg_t;

  typedef enum logic {
    IDLE,
    SCAN
  } sched_state_t;

endpackage

// File: rtl/voice_phase.sv
// One oscillator voice: phase counter plus config shadows that only
// reload at a period boundary, so a new setting never splits a period.
module voice_phase
  import sass_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             en_i,
  input  voice_cfg_t       cfg_i,
  output logic [CNT_W-1:0] cnt_o,
  output voice_cfg_t       shadow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  voice_cfg_t       shadow_q, shadow_d;
  logic             wrap;

  // Divisors of 0 and 1 are degenerate periods: wrap on every cycle.
  always_comb begin
    wrap = (shadow_q.divisor < CNT_W'(2)) ||
           (cnt_q >= shadow_q.divisor - CNT_W'(1));
  end

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (!en_i) begin
      cnt_d    = '0;
      shadow_d = cfg_i;
    end else if (advance_i) begin
      if (wrap) begin
        cnt_d    = '0;
        shadow_d = cfg_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign shadow_o = shadow_q;

endmodule

// File: rtl/voice_scheduler.sv
// Round-robin scheduler sharing one combinational waveshaper across all
// voices and averaging the returned samples into one mixed sample per frame.
module voice_scheduler
  import sass_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                         clk,
  input  logic                         Rst_i,
  input  logic                         run_i,
  input  logic [NUM_VOICES-1:0]        en_i,
  input  logic [NUM_VOICES*CNT_W-1:0]  divisor_i,
  input  logic [NUM_VOICES*MODE_W-1:0] mode_i,
  input  logic [NUM_VOICES*8-1:0]      level_i,
  output logic [CNT_W-1:0]             ws_count_o,
  output logic [CNT_W-1:0]             ws_divisor_o,
  output logic [MODE_W-1:0]            ws_mode_o,
  output logic [SAMPLE_W-1:0]          ws_Q_o,
  input  logic [SAMPLE_W-1:0]          ws_sample_i,
  output logic [SAMPLE_W-1:0]          mix_o,
  output logic                         mix_valid_o,
  output logic                         busy_o
);

  localparam int unsigned LOG2_NV = $clog2(NUM_VOICES);
  localparam int unsigned SLOT_W  = LOG2_NV;
  localparam int unsigned ACC_W   = SAMPLE_W + LOG2_NV;

  sched_state_t        state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0] mix_q, mix_d;
  logic                valid_q, valid_d;

  logic                scan;
  logic                last_slot;
  logic [SAMPLE_W-1:0] term;
  logic [ACC_W-1:0]    sum;

  logic [CNT_W-1:0]    cnt    [NUM_VOICES];
  voice_cfg_t          shadow [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_cfg_t cfg;
    assign cfg.divisor = divisor_i[CNT_W*v +: CNT_W];
    assign cfg.mode    = mode_i[MODE_W*v +: MODE_W];
    assign cfg.level   = level_i[SAMPLE_W*v +: SAMPLE_W];

    voice_phase u_phase (
      .clk       (clk),
      .rst_n     (Rst_i),
      .advance_i (scan),
      .en_i      (en_i[v]),
      .cfg_i     (cfg),
      .cnt_o     (cnt[v]),
      .shadow_o  (shadow[v])
    );
  end

  always_comb begin
    last_slot = (slot_q == SLOT_W'(NUM_VOICES - 1));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; a falling run_i only takes effect at the frame end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run_i) state_d = SCAN;
      SCAN:    if (last_slot && !run_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    scan   = (state_q == SCAN);
    busy_o = scan;
  end

  always_comb begin
    term    = en_i[slot_q] ? ws_sample_i : MIDSCALE;
    sum     = acc_q + ACC_W'(term);
    slot_d  = '0;
    acc_d   = acc_q;
    mix_d   = mix_q;
    valid_d = 1'b0;
    if (scan) begin
      slot_d = slot_q + SLOT_W'(1);
      if (last_slot) begin
        mix_d   = sum[ACC_W-1:LOG2_NV];
        valid_d = 1'b1;
        acc_d   = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      slot_q  <= '0;
      acc_q   <= '0;
      mix_q   <= MIDSCALE;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    ws_count_o   = cnt[slot_q];
    ws_divisor_o = shadow[slot_q].divisor;
    ws_mode_o    = shadow[slot_q].mode;
    ws_Q_o       = shadow[slot_q].level;
  end

  assign mix_o       = mix_q;
  assign mix_valid_o = valid_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed and randomized checks of voice_scheduler against a cycle-level
// behavioural model of voices, frames and mixing.
module tb_voice_scheduler;

  localparam int NV = 4;

  logic            clk;
  logic            Rst_i;
  logic            run_i;
  logic [NV-1:0]   en_i;
  logic [NV*19-1:0] divisor_i;
  logic [NV*3-1:0] mode_i;
  logic [NV*8-1:0] level_i;
  logic [18:0]     ws_count_o, ws_divisor_o;
  logic [2:0]      ws_mode_o;
  logic [7:0]      ws_Q_o, ws_sample_i, mix_o;
  logic            mix_valid_o, busy_o;

  voice_scheduler #(.NUM_VOICES(NV)) dut (
    .clk          (clk),
    .Rst_i        (Rst_i),
    .run_i        (run_i),
    .en_i         (en_i),
    .divisor_i    (divisor_i),
    .mode_i       (mode_i),
    .level_i      (level_i),
    .ws_count_o   (ws_count_o),
    .ws_divisor_o (ws_divisor_o),
    .ws_mode_o    (ws_mode_o),
    .ws_Q_o       (ws_Q_o),
    .ws_sample_i  (ws_sample_i),
    .mix_o        (mix_o),
    .mix_valid_o  (mix_valid_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_scan;
  int m_slot, m_acc, m_mix;
  bit m_valid;
  int m_cnt[NV], m_sdiv[NV], m_smode[NV], m_slev[NV];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_slot = 0; m_acc = 0; m_mix = 128; m_valid = 0;
    for (int v = 0; v < NV; v++) begin
      m_cnt[v] = 0; m_sdiv[v] = 0; m_smode[v] = 0; m_slev[v] = 0;
    end
  endtask

  task automatic model_load(input int v);
    m_sdiv[v]  = int'(divisor_i[19*v +: 19]);
    m_smode[v] = int'(mode_i[3*v +: 3]);
    m_slev[v]  = int'(level_i[8*v +: 8]);
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_next();
    int term;
    for (int v = 0; v < NV; v++) begin
      if (!en_i[v]) begin
        m_cnt[v] = 0;
        model_load(v);
      end else if (m_scan) begin
        m_cnt[v] = (m_sdiv[v] < 2) ? 0 : (m_cnt[v] + 1) % m_sdiv[v];
        if (m_cnt[v] == 0) model_load(v);
      end
    end
    m_valid = 0;
    if (m_scan) begin
      term  = en_i[m_slot] ? int'(ws_sample_i) : 128;
      m_acc = m_acc + term;
      if (m_slot == NV - 1) begin
        m_mix   = m_acc / NV;
        m_acc   = 0;
        m_valid = 1;
        m_scan  = run_i;
      end
      m_slot = (m_slot + 1) % NV;
    end else if (run_i) begin
      m_scan = 1;
    end
  endtask

  task automatic check_all();
    chk("busy",       busy_o,       m_scan);
    chk("mix_valid",  mix_valid_o,  m_valid);
    chk("mix",        mix_o,        m_mix);
    chk("ws_count",   ws_count_o,   m_cnt[m_slot]);
    chk("ws_divisor", ws_divisor_o, m_sdiv[m_slot]);
    chk("ws_mode",    ws_mode_o,    m_smode[m_slot]);
    chk("ws_Q",       ws_Q_o,       m_slev[m_slot]);
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!mix_valid_o && n < 16);
    chk(tag, mix_valid_o, 1);
  endtask

  task automatic goto_slot(input int s);
    int n = 0;
    do begin
      step();
      n++;
    end while (m_slot != s && n < 8);
  endtask

  task automatic set_div(input int v, input int val);
    divisor_i[19*v +: 19] = 19'(val);
  endtask

  initial begin
    int phase_exp[4];
    int n;
    int pulses;
    phase_exp = '{0, 4, 3, 2};

    Rst_i = 1'b0; run_i = 1'b0; en_i = '0;
    divisor_i = '0; mode_i = '0; level_i = '0; ws_sample_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mix",   mix_o,       128);
    chk("rst_valid", mix_valid_o, 0);
    chk("rst_busy",  busy_o,      0);
    chk("rst_count", ws_count_o,  0);
    Rst_i = 1'b1;

    // Phase counter of a single enabled voice with divisor 5
    set_div(0, 5);
    step(); step();
    en_i = 4'b0001; run_i = 1'b1;
    step();
    for (int k = 0; k <= 12; k++) begin
      if (k % 4 == 0) chk("phase_slot0", ws_count_o, phase_exp[k/4]);
      ws_sample_i = 8'($urandom);
      step();
    end

    // Asynchronous reset in the middle of a frame
    step();
    Rst_i = 1'b0;
    #1;
    chk("rst_mid_mix",   mix_o,       128);
    chk("rst_mid_valid", mix_valid_o, 0);
    chk("rst_mid_busy",  busy_o,      0);
    chk("rst_mid_count", ws_count_o,  0);
    model_reset();
    @(negedge clk);
    Rst_i = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!mix_valid_o && n < 20);
    chk("first_valid_lat", n, 5);

    // Mixing: full-scale on all voices, then two zero voices with two idle at midscale
    en_i = 4'b1111; ws_sample_i = 8'd255;
    wait_valid("align_a");
    wait_valid("mix255_valid");
    chk("mix_255", mix_o, 255);
    en_i = 4'b0011; ws_sample_i = 8'd0;
    wait_valid("mix64_valid");
    chk("mix_64", mix_o, 64);

    // Shadowed divisor change only lands at the wrap
    en_i = 4'b0000;
    set_div(1, 1000);
    step();
    en_i = 4'b0010;
    repeat (600) step();
    set_div(1, 3000);
    goto_slot(1);
    chk("shadow_old", ws_divisor_o, 1000);
    repeat (1000) step();
    goto_slot(1);
    chk("shadow_new", ws_divisor_o, 3000);
    set_div(2, 777);
    step();
    goto_slot(2);
    chk("shadow_disabled", ws_divisor_o, 777);

    // Degenerate divisors 0 and 1
    en_i = 4'b0001;
    set_div(0, 0);
    repeat (12) step();
    goto_slot(0);
    chk("deg0_count", ws_count_o, 0);
    chk("deg0_div",   ws_divisor_o, 0);
    set_div(0, 1);
    repeat (12) step();
    goto_slot(0);
    chk("deg1_count", ws_count_o, 0);
    chk("deg1_div",   ws_divisor_o, 1);

    // Randomized configuration and samples
    for (int i = 0; i < 320; i++) begin
      if (i % 16 == 0) begin
        en_i = 4'($urandom);
        for (int v = 0; v < NV; v++) begin
          set_div(v, int'($urandom_range(0, 12)));
          mode_i[3*v +: 3]  = 3'($urandom);
          level_i[8*v +: 8] = 8'($urandom);
        end
      end
      ws_sample_i = 8'($urandom);
      step();
    end

    // Stop mid-frame: frame completes, one strobe, then idle
    goto_slot(1);
    run_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      ws_sample_i = 8'($urandom);
      step();
      if (mix_valid_o) pulses++;
    end
    chk("stop_pulses", pulses, 1);
    chk("stop_busy",   busy_o, 0);
    chk("stop_frozen", ws_count_o, m_cnt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
